// File: rtl/cache_defs_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states,
// default geometry, memory burst-length encodings and address helpers.
package cache_defs;

    localparam int DEF_INDEX_W  = 6;
    localparam int DEF_OFFSET_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_REQ,
        ST_REFILL,
        ST_RESP
    } state_e;

    // Burst length is encoded as beats-1.
    localparam logic [1:0] MEM_LEN_SINGLE = 2'd0;

    function automatic logic [1:0] mem_len_refill(input int offset_w);
        return 2'((1 << (offset_w - 2)) - 1);
    endfunction

    function automatic logic [31:0] line_align(input logic [31:0] addr, input int offset_w);
        return addr & ~((32'd1 << offset_w) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Line data store: one 32-bit word per (index, word) slot, synchronous
// per-word write and asynchronous read so hits return in the lookup cycle.
module icache_data_ram
    import cache_defs::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int WORD_W  = DEF_OFFSET_W - 2
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_windex,
    input  logic [WORD_W-1:0]  i_wword,
    input  logic [31:0]        i_wdata,
    input  logic [INDEX_W-1:0] i_rindex,
    input  logic [WORD_W-1:0]  i_rword,
    output logic [31:0]        o_rdata
);

    localparam int DEPTH = 1 << (INDEX_W + WORD_W);

    logic [31:0] r_mem [DEPTH];

    // NOTE: the array has no reset; valid bits in the top decide whether
    // its contents mean anything, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[{i_windex, i_wword}] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[{i_rindex, i_rword}];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: single-cycle hits, burst line
// refills on a miss, single-word reads for uncached fetches.
module icache_dm
    import cache_defs::*;
#(
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_uncached,
    output logic        cpu_ready,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_len,
    input  logic        mem_addr_ok,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rlast
);

    localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
    localparam int WORD_W = OFFSET_W - 2;
    localparam int LINES  = 1 << INDEX_W;
    localparam logic [1:0] LEN_REFILL = mem_len_refill(OFFSET_W);

    state_e             r_state;
    state_e             w_next;
    logic [31:0]        r_addr;
    logic               r_uncached;
    logic [1:0]         r_beat;
    logic [31:0]        r_bypass;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag [LINES];

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic [WORD_W-1:0]  w_word;
    logic [WORD_W-1:0]  w_beat_word;
    logic [1:0]         w_len;
    logic               w_hit;
    logic               w_beat;
    logic               w_last;
    logic               w_fill_done;
    logic [31:0]        w_ram_rdata;

    assign w_index     = r_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign w_tag       = r_addr[31:OFFSET_W+INDEX_W];
    assign w_word      = r_addr[OFFSET_W-1:2];
    assign w_beat_word = WORD_W'(r_beat);
    assign w_len       = r_uncached ? MEM_LEN_SINGLE : LEN_REFILL;
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag) && !r_uncached;
    assign w_beat      = (r_state == ST_REFILL) && mem_rvalid;
    assign w_last      = (r_beat == w_len);
    assign w_fill_done = !rst && w_beat && w_last && !r_uncached;

    icache_data_ram #(
        .INDEX_W (INDEX_W),
        .WORD_W  (WORD_W)
    ) u_data_ram (
        .clk      (clk),
        .i_we     (!rst && w_beat && !r_uncached),
        .i_windex (w_index),
        .i_wword  (w_beat_word),
        .i_wdata  (mem_rdata),
        .i_rindex (w_index),
        .i_rword  (w_word),
        .o_rdata  (w_ram_rdata)
    );

    // NOTE: every output and w_next gets a default before the case, so no
    // path through this block can leave a latch behind.
    always_comb begin
        w_next      = r_state;
        cpu_ready   = 1'b0;
        cpu_data_ok = 1'b0;
        cpu_rdata   = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        mem_len     = '0;
        case (r_state)
            ST_IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) w_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    cpu_ready   = 1'b1;
                    cpu_data_ok = 1'b1;
                    cpu_rdata   = w_ram_rdata;
                    w_next      = cpu_req ? ST_LOOKUP : ST_IDLE;
                end else begin
                    w_next = ST_MISS_REQ;
                end
            end
            ST_MISS_REQ: begin
                mem_req  = 1'b1;
                mem_addr = r_uncached ? r_addr : line_align(r_addr, OFFSET_W);
                mem_len  = w_len;
                if (mem_addr_ok) w_next = ST_REFILL;
            end
            ST_REFILL: begin
                if (mem_rvalid && w_last) w_next = ST_RESP;
            end
            ST_RESP: begin
                cpu_data_ok = 1'b1;
                cpu_rdata   = r_bypass;
                w_next      = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_uncached <= 1'b0;
            r_beat     <= '0;
            r_bypass   <= '0;
            r_valid    <= '0;
        end else begin
            r_state <= w_next;
            if (cpu_req && cpu_ready) begin
                r_addr     <= cpu_addr;
                r_uncached <= cpu_uncached;
            end
            if (w_beat) begin
                // The requested word is kept aside so RESP never reads the array.
                if (r_uncached || (w_beat_word == w_word)) r_bypass <= mem_rdata;
                r_beat <= w_last ? 2'd0 : r_beat + 2'd1;
                if (w_fill_done) r_valid[w_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_tag[w_index] <= w_tag;
        end
    end

    a_rlast_matches_counter : assert property (
        @(posedge clk) disable iff (rst)
        (r_state == ST_REFILL && mem_rvalid) |-> (mem_rlast == w_last)
    ) else $error("icache_dm: mem_rlast disagrees with the beat counter");

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: fills, hits, conflicts, uncached reads,
// memory back-pressure and reset in the middle of a refill.
module tb_icache_dm;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_uncached;
    logic        cpu_ready;
    logic        cpu_data_ok;
    logic [31:0] cpu_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic        mem_addr_ok;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rlast;

    int n_cmp = 0;
    int n_bad = 0;

    icache_dm dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_uncached (cpu_uncached),
        .cpu_ready    (cpu_ready),
        .cpu_data_ok  (cpu_data_ok),
        .cpu_rdata    (cpu_rdata),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_len      (mem_len),
        .mem_addr_ok  (mem_addr_ok),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .mem_rlast    (mem_rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  32'(cpu_ready),   32'd1);
        check({tag, "_dok"},    32'(cpu_data_ok), 32'd0);
        check({tag, "_rdata"},  cpu_rdata,        32'd0);
        check({tag, "_memreq"}, 32'(mem_req),     32'd0);
        check({tag, "_maddr"},  mem_addr,         32'd0);
        check({tag, "_mlen"},   32'(mem_len),     32'd0);
    endtask

    // Called on a negedge with the cache idle; returns on the LOOKUP negedge.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic unc);
        check({tag, "_accept"}, 32'(cpu_ready), 32'd1);
        cpu_req      = 1'b1;
        cpu_addr     = addr;
        cpu_uncached = unc;
        @(negedge clk);
        cpu_req      = 1'b0;
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] exp);
        check({tag, "_hit_dok"},   32'(cpu_data_ok), 32'd1);
        check({tag, "_hit_rdata"}, cpu_rdata,        exp);
        check({tag, "_hit_noreq"}, 32'(mem_req),     32'd0);
        @(negedge clk);
        check({tag, "_hit_pulse"}, 32'(cpu_data_ok), 32'd0);
    endtask

    task automatic expect_miss(input string tag);
        check({tag, "_miss_dok"},   32'(cpu_data_ok), 32'd0);
        check({tag, "_miss_ready"}, 32'(cpu_ready),   32'd0);
    endtask

    // Memory side of one miss: request checks, optional accept delay, beats, response.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [1:0] exp_len,
                         input int delay, input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3, input logic [31:0] exp_rdata);
        logic [31:0] beats [4];
        int n;
        beats = '{b0, b1, b2, b3};
        n = int'(exp_len) + 1;
        for (int i = 0; i < 8 && !mem_req; i++) begin
            check({tag, "_wait_dok"}, 32'(cpu_data_ok), 32'd0);
            @(negedge clk);
        end
        check({tag, "_req"},   32'(mem_req),   32'd1);
        check({tag, "_maddr"}, mem_addr,       exp_addr);
        check({tag, "_mlen"},  32'(mem_len),   32'(exp_len));
        check({tag, "_ready"}, 32'(cpu_ready), 32'd0);
        for (int i = 0; i < delay; i++) begin
            check({tag, "_hold_req"},   32'(mem_req),   32'd1);
            check({tag, "_hold_addr"},  mem_addr,       exp_addr);
            check({tag, "_hold_len"},   32'(mem_len),   32'(exp_len));
            check({tag, "_hold_ready"}, 32'(cpu_ready), 32'd0);
            @(negedge clk);
        end
        mem_addr_ok = 1'b1;
        @(negedge clk);
        mem_addr_ok = 1'b0;
        check({tag, "_noreq"}, 32'(mem_req), 32'd0);
        for (int k = 0; k < n; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = beats[k];
            mem_rlast  = (k == n - 1);
            @(negedge clk);
            if (k < n - 1) begin
                check({tag, "_beat_dok"},   32'(cpu_data_ok), 32'd0);
                check({tag, "_beat_noreq"}, 32'(mem_req),     32'd0);
            end
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        check({tag, "_resp_dok"},   32'(cpu_data_ok), 32'd1);
        check({tag, "_resp_rdata"}, cpu_rdata,        exp_rdata);
        check({tag, "_resp_ready"}, 32'(cpu_ready),   32'd0);
        @(negedge clk);
        check({tag, "_resp_pulse"}, 32'(cpu_data_ok), 32'd0);
        check({tag, "_idle_ready"}, 32'(cpu_ready),   32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        cpu_req      = 1'b0;
        cpu_addr     = '0;
        cpu_uncached = 1'b0;
        mem_addr_ok  = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        mem_rlast    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        // 1: cold miss, line refill with zero-wait accept.
        fetch("t1", 32'h1FC0_0000, 1'b0);
        expect_miss("t1");
        serve("t1", 32'h1FC0_0000, 2'd3, 0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h11);

        // 2: hits, including back-to-back acceptance in LOOKUP.
        fetch("t2a", 32'h1FC0_0008, 1'b0);
        expect_hit("t2a", 32'h33);
        fetch("t2b", 32'h1FC0_0000, 1'b0);
        check("t2b_dok",   32'(cpu_data_ok), 32'd1);
        check("t2b_rdata", cpu_rdata,        32'h11);
        check("t2b_ready", 32'(cpu_ready),   32'd1);
        cpu_req  = 1'b1;
        cpu_addr = 32'h1FC0_0004;
        @(negedge clk);
        cpu_req = 1'b0;
        expect_hit("t2c", 32'h22);

        // 3: conflict on index 0 evicts the first line.
        fetch("t3a", 32'h1FC0_0400, 1'b0);
        expect_miss("t3a");
        serve("t3a", 32'h1FC0_0400, 2'd3, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0);
        fetch("t3b", 32'h1FC0_040C, 1'b0);
        expect_hit("t3b", 32'hA3);
        fetch("t3c", 32'h1FC0_0000, 1'b0);
        expect_miss("t3c");
        serve("t3c", 32'h1FC0_0000, 2'd3, 0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h11);

        // 4: uncached reads bypass the array and never allocate.
        fetch("t4a", 32'h1FAF_0004, 1'b1);
        expect_miss("t4a");
        serve("t4a", 32'h1FAF_0004, 2'd0, 0, 32'h5555, 32'h0, 32'h0, 32'h0, 32'h5555);
        fetch("t4b", 32'h1FAF_0004, 1'b1);
        expect_miss("t4b");
        serve("t4b", 32'h1FAF_0004, 2'd0, 0, 32'h6666, 32'h0, 32'h0, 32'h0, 32'h6666);
        fetch("t4c", 32'h1FC0_0004, 1'b0);
        expect_hit("t4c", 32'h22);

        // 5: memory holds off acceptance for five cycles.
        fetch("t5", 32'h1FC0_0018, 1'b0);
        expect_miss("t5");
        serve("t5", 32'h1FC0_0010, 2'd3, 5, 32'h100, 32'h101, 32'h102, 32'h103, 32'h102);
        fetch("t5b", 32'h1FC0_0014, 1'b0);
        expect_hit("t5b", 32'h101);

        // 6: reset after two refill beats, stray beats, then refetch.
        fetch("t6", 32'h1FC0_0020, 1'b0);
        expect_miss("t6");
        @(negedge clk);
        check("t6_req", 32'(mem_req), 32'd1);
        mem_addr_ok = 1'b1;
        @(negedge clk);
        mem_addr_ok = 1'b0;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'hDEAD_0000;
        @(negedge clk);
        mem_rdata   = 32'hDEAD_0001;
        @(negedge clk);
        mem_rvalid  = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("t6_rst");
        mem_rvalid = 1'b1;
        mem_rlast  = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6_stray_dok", 32'(cpu_data_ok), 32'd0);
            check("t6_stray_req", 32'(mem_req),     32'd0);
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        fetch("t6b", 32'h1FC0_0020, 1'b0);
        expect_miss("t6b");
        serve("t6b", 32'h1FC0_0020, 2'd3, 0, 32'h200, 32'h201, 32'h202, 32'h203, 32'h200);
        fetch("t6c", 32'h1FC0_0000, 1'b0);
        expect_miss("t6c");
        serve("t6c", 32'h1FC0_0000, 2'd3, 0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
